// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter - serialises two requesters onto one sync-read RAM port.
// Macro ARB_RR_EN selects round-robin tie-break; otherwise r0 has fixed priority.
// Rev 1.0
// ============================================================================
module ram_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic          win1;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] wdata_nx;
  logic          we_nx;
  logic          gnt0_nx, gnt1_nx;
  logic          rv0_nx, rv1_nx;
  logic [DW-1:0] rdata0_nx, rdata1_nx;

`ifdef ARB_RR_EN
  logic last_owner, last_owner_nx;
  // On a tie the requester that did not win last time goes first
  assign win1 = r1_req & (~r0_req | ~last_owner);
`else
  assign win1 = r1_req & ~r0_req;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    addr_nx   = ram_addr;
    wdata_nx  = ram_wdata;
    we_nx     = 1'b0;
    gnt0_nx   = 1'b0;
    gnt1_nx   = 1'b0;
    rv0_nx    = 1'b0;
    rv1_nx    = 1'b0;
    rdata0_nx = r0_rdata;
    rdata1_nx = r1_rdata;
`ifdef ARB_RR_EN
    last_owner_nx = last_owner;
`endif
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          owner_nx = win1;
          addr_nx  = win1 ? r1_addr  : r0_addr;
          wdata_nx = win1 ? r1_wdata : r0_wdata;
          we_nx    = win1 ? r1_we    : r0_we;
          gnt0_nx  = ~win1;
          gnt1_nx  = win1;
          state_nx = ACCESS;
`ifdef ARB_RR_EN
          last_owner_nx = win1;
`endif
        end
      end
      // ram_we is high in ACCESS exactly when the access is a write
      ACCESS: state_nx = ram_we ? IDLE : RDWAIT;
      RDWAIT: begin
        if (owner) begin
          rdata1_nx = ram_rdata;
          rv1_nx    = 1'b1;
        end else begin
          rdata0_nx = ram_rdata;
          rv0_nx    = 1'b1;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
`ifdef ARB_RR_EN
      last_owner <= 1'b1;
`endif
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      ram_addr  <= addr_nx;
      ram_wdata <= wdata_nx;
      ram_we    <= we_nx;
      r0_gnt    <= gnt0_nx;
      r1_gnt    <= gnt1_nx;
      r0_rvalid <= rv0_nx;
      r1_rvalid <= rv1_nx;
      r0_rdata  <= rdata0_nx;
      r1_rdata  <= rdata1_nx;
`ifdef ARB_RR_EN
      last_owner <= last_owner_nx;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// tb_ram_port_arbiter - directed stimulus against a timeline model of the arbiter,
// with a per-cycle output compare and literal spot checks.
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  // Single-port synchronous-read RAM
  logic [DW-1:0] ram_mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: each accepted request books its future cycles in a ring of slots
  int          cyc = 0;
  bit          model_ok = 1'b0;
  int          free_at = 0;
  bit          m_last = 1'b1;
  logic [31:0] mem_m [256] = '{default: '0};
  logic [7:0]  e_addr = '0;
  logic [31:0] e_wdata = '0, e_rd0 = '0, e_rd1 = '0;
  bit          sg0 [8], sg1 [8], swe [8], sbusy [8], srv0 [8], srv1 [8], sset [8];
  logic [7:0]  sa [8];
  logic [31:0] swd [8], srd [8];

  task automatic clr_slot(input int k);
    sg0[k] = 0; sg1[k] = 0; swe[k] = 0; sbusy[k] = 0;
    srv0[k] = 0; srv1[k] = 0; sset[k] = 0;
  endtask

  always @(posedge clk) begin : model
    int s;
    bit w, we;
    logic [7:0] a;
    logic [31:0] d;
    s = cyc % 8;
    if (model_ok && swe[s]) mem_m[sa[s]] = swd[s];
    clr_slot(s);
    if (rst) begin
      for (int k = 0; k < 8; k++) clr_slot(k);
      e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
      free_at = cyc + 1; m_last = 1'b1; model_ok = 1'b1;
    end else if (model_ok && cyc >= free_at && (r0_req || r1_req)) begin
      if (r0_req && r1_req) w = RR ? ~m_last : 1'b0;
      else                  w = r1_req;
      we = w ? r1_we : r0_we;
      a  = w ? r1_addr : r0_addr;
      d  = w ? r1_wdata : r0_wdata;
      sset[(cyc+1)%8] = 1; sa[(cyc+1)%8] = a; swd[(cyc+1)%8] = d;
      swe[(cyc+1)%8] = we; sbusy[(cyc+1)%8] = 1;
      if (w) sg1[(cyc+1)%8] = 1; else sg0[(cyc+1)%8] = 1;
      if (we) free_at = cyc + 2;
      else begin
        sbusy[(cyc+2)%8] = 1;
        srd[(cyc+3)%8] = mem_m[a];
        if (w) srv1[(cyc+3)%8] = 1; else srv0[(cyc+3)%8] = 1;
        free_at = cyc + 3;
      end
      m_last = w;
    end
    cyc++;
    s = cyc % 8;
    if (sset[s]) begin e_addr = sa[s]; e_wdata = swd[s]; end
    if (srv0[s]) e_rd0 = srd[s];
    if (srv1[s]) e_rd1 = srd[s];
    #1;
    if (model_ok) begin
      chk("m_r0_gnt", r0_gnt, sg0[s]);
      chk("m_r1_gnt", r1_gnt, sg1[s]);
      chk("m_ram_we", ram_we, swe[s]);
      chk("m_busy", busy, sbusy[s]);
      chk("m_r0_rvalid", r0_rvalid, srv0[s]);
      chk("m_r1_rvalid", r1_rvalid, srv1[s]);
      chk("m_ram_addr", ram_addr, e_addr);
      chk("m_ram_wdata", ram_wdata, e_wdata);
      chk("m_r0_rdata", r0_rdata, e_rd0);
      chk("m_r1_rdata", r1_rdata, e_rd1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit req, input bit we, input logic [7:0] a,
                       input logic [31:0] d);
    if (r) begin r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d; end
    else   begin r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d; end
  endtask

  task automatic do_access(input bit r, input bit we, input logic [7:0] a, input logic [31:0] d);
    bit g = 1'b0;
    drive(r, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !g; i++) begin
      tick();
      g = r ? r1_gnt : r0_gnt;
    end
    if (!g) chk("gnt_timeout", 32'd0, 32'd1);
    tick();
    drive(r, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_idle();
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    for (int i = 0; i < 10 && busy; i++) tick();
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    tick(); tick();
  endtask

  initial begin : stim
    int seq[$];
    int r1cnt;
    bit got;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rdata", {r0_rdata | r1_rdata}, 0);
    chk("rst_outs", {ram_we, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, 0);

    // r0 write then read of 0x64
    drive(0, 1, 1, 8'h64, 32'hDEADBEEF);
    tick();
    chk("wr_gnt", r0_gnt, 1); chk("wr_we", ram_we, 1); chk("wr_addr", ram_addr, 8'h64);
    tick();
    drive(0, 1, 0, 8'h64, 0);
    tick();
    chk("rd_gnt", r0_gnt, 1); chk("rd_we", ram_we, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("rd_rvalid_early", r0_rvalid, 0);
    tick();
    chk("rd_rvalid", r0_rvalid, 1); chk("rd_rdata", r0_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_rvalid_pulse", r0_rvalid, 0); chk("rd_rdata_hold", r0_rdata, 32'hDEADBEEF);
    wait_idle();

    // r1 write waits while r0 owns a read
    drive(0, 1, 0, 8'h64, 0);
    tick();
    chk("lose_r0_gnt", r0_gnt, 1); chk("lose_we_a", ram_we, 0);
    drive(1, 1, 1, 8'h05, 32'h12345678);
    tick();
    chk("lose_r1_gnt_a", r1_gnt, 0); chk("lose_we_b", ram_we, 0);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("lose_r1_gnt_b", r1_gnt, 0); chk("lose_r0_rv", r0_rvalid, 1);
    tick();
    chk("lose_r1_gnt", r1_gnt, 1); chk("lose_wr_we", ram_we, 1);
    chk("lose_wr_addr", ram_addr, 8'h05); chk("lose_wr_data", ram_wdata, 32'h12345678);
    tick();
    drive(1, 0, 0, 0, 0);
    wait_idle();

    // Preload tie addresses through r1 so last winner is r1
    do_access(1, 1, 8'h00, 32'hA0A0A0A0);
    do_access(1, 1, 8'hC8, 32'hC8C8C8C8);
    wait_idle();

    // Tie: both hold continuous reads
    drive(0, 1, 0, 8'h00, 0);
    drive(1, 1, 0, 8'hC8, 0);
    r1cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (r0_gnt) seq.push_back(0);
      if (r1_gnt) begin seq.push_back(1); r1cnt++; end
      if (r0_rvalid) chk("tie_r0_data", r0_rdata, 32'hA0A0A0A0);
      if (r1_rvalid) chk("tie_r1_data", r1_rdata, 32'hC8C8C8C8);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_order%0d", i), (seq.size() > i) ? seq[i] : -1, RR ? (i % 2) : 0);
    chk("tie_r1_grants", r1cnt, RR ? 2 : 0);
    drive(0, 0, 0, 0, 0);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = r1_gnt;
    end
    chk("r1_after_r0_drop", got, 1);
    tick();
    wait_idle();

    // Reset during RDWAIT
    drive(1, 1, 0, 8'hC8, 0);
    tick();
    chk("rr_gnt", r1_gnt, 1);
    tick();
    rst = 1'b1;
    drive(1, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk("rr_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("rr_busy", busy, 0); chk("rr_addr", ram_addr, 0);
    chk("rr_rdata", r1_rdata, 0); chk("rr_wdata", ram_wdata, 0);
    tick();
    chk("rr_rvalid_late", {r0_rvalid, r1_rvalid}, 0);
    do_access(1, 0, 8'hC8, 0);
    tick();
    chk("fresh_rvalid", r1_rvalid, 1); chk("fresh_rdata", r1_rdata, 32'hC8C8C8C8);
    wait_idle();

    // Idle hygiene
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_quiet", {ram_we, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares the single-port, synchronous-read data RAM between the arithmetic sequencer (requester 0) and the host/debug load port (requester 1). Each requester issues one read or write per request/grant handshake. The arbiter serialises the accesses, drives the RAM port, and returns read data with a valid pulse. It sits between both requesters and the RAM instance in the lab top level.

## Interface
- AW, 8, RAM address width
- DW, 32, RAM data width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- r0_req / r1_req  in  1  access request, held until grant
- r0_we / r1_we  in  1  1 = write, 0 = read; stable while req high
- r0_addr / r1_addr  in  AW  access address; stable while req high
- r0_wdata / r1_wdata  in  DW  write data; stable while req high
- r0_gnt / r1_gnt  out  1  one-cycle grant pulse
- r0_rvalid / r1_rvalid  out  1  one-cycle read-data-valid pulse
- r0_rdata / r1_rdata  out  DW  read data, valid when rvalid, holds until next read for that requester
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid the cycle after the address is presented
- busy  out  1  high in ACCESS and RDWAIT

## Operation
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE: if any req is high, select the winner. Register owner, ram_addr, ram_wdata, ram_we (= winner's we), and winner's gnt. Next state: ACCESS. No req: stay in IDLE.
- ACCESS: RAM port carries the winner's request. gnt of the winner is high for exactly this cycle. ram_we is high only if the access is a write. Next state: RDWAIT for a read, IDLE for a write.
- RDWAIT: ram_rdata is captured into the owner's rdata register, and the owner's rvalid is set for the following cycle. ram_we = 0. Next state: IDLE.
- Requester rule: drop req, or present a new request, in the cycle after gnt is seen. A req still high in IDLE is treated as a new access.
- Tie (both req high in IDLE): resolved per Configuration. A single requester always wins.
- The non-owner's req is ignored outside IDLE. Its gnt stays 0, and it waits with inputs held.
- ram_addr and ram_wdata hold their last values in IDLE. ram_we is 0 in every state except ACCESS-write.
- Reset values: state IDLE, all gnt/rvalid 0, ram_we 0, ram_addr 0, ram_wdata 0, r0_rdata/r1_rdata 0, busy 0, last_owner 1.
- Reset mid-access: everything returns to reset values on the next edge. No rvalid is issued for the aborted read. A write already presented in ACCESS in that same cycle may land in RAM.

## Timing
- Request seen in IDLE at cycle N: gnt and RAM drive at N+1. Write lands at the end of N+1.
- Read: ram_rdata valid in N+2. rvalid and rdata at N+3, with the FSM already back in IDLE.
- Back-to-back throughput: one write per 2 cycles, one read per 3 cycles.
- rvalid in cycle N+3 may coincide with a new arbitration in IDLE. This is legal.

## Configuration
- ARB_RR_EN defined: round-robin. On a tie, the requester that is not last_owner wins. last_owner updates on every grant. Reset value 1, so requester 0 wins the first tie.
- ARB_RR_EN undefined: fixed priority. Requester 0 always wins ties. last_owner logic is not compiled.

## Test plan
- Write then read: r0 writes 0xDEADBEEF to 0x64, then reads 0x64 -> r0_gnt at N+1 with ram_we=1 and ram_addr=0x64. The read returns r0_rvalid with r0_rdata=0xDEADBEEF exactly 3 cycles after its req.
- Tie, round-robin (ARB_RR_EN): r0 and r1 hold continuous reads at 0x00 and 0xC8 -> grants alternate r0, r1, r0, r1. Each rvalid goes only to the matching requester with the correct data.
- Tie, fixed priority (ARB_RR_EN off): r0 re-requests every IDLE -> r1 is never granted while r0 requests. r1 is granted the first IDLE in which r0_req=0.
- Losing requester waits: r1 writes 0x12345678 to 0x05 while r0 owns a read -> r1_gnt only after r0's RDWAIT. ram_we=0 throughout r0's access.
- Reset mid-read: assert rst during RDWAIT -> no rvalid on either port. All outputs are 0 the next cycle. A fresh r1 read then completes normally.
- Idle hygiene: no requests for 20 cycles -> ram_we, gnt, rvalid and busy all stay 0.
